fp_divider: RTL and testbench
=============================

Name: fp_divider

Overview:
- Iterative IEEE-754 single-precision divider computing result = a / b. It is the inverse companion to the combinational FP32 multiplier in the accelerator datapath.
- Multi-cycle: a restoring mantissa division produces one quotient bit per clock.
- Valid/ready handshake on both input and output, so it drops into the accelerator's streaming pipeline.
- Same numeric simplifications as the multiplier: implicit-1 operands, truncation rounding, no denormal/NaN support.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored mantissa field width.
- BIAS, 127, exponent bias. Must equal 2^(EXP_W-1)-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands a, b present.
- in_ready  output  1  divider idle, can accept.
- a  input  32  dividend, FP32.
- b  input  32  divisor, FP32.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  32  quotient, FP32.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high. Reset mid-operation aborts the operation, discards any result and returns to IDLE.
- Reset values: in_ready=1, out_valid=0, result=0, busy=0, state=IDLE. All internal registers are cleared.
- States: IDLE, DIV, NORM, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge T, capture the operands:
  - sign = a[31]^b[31].
  - ma = {1,a[22:0]}, mb = {1,b[22:0]}.
  - exp_t = a[30:23] - b[30:23] + BIAS, held as signed EXP_W+2 bits.
- Zero detection: an operand is zero when its exponent field is 0, whatever its mantissa (flush-to-zero).
- Special cases bypass DIV and go IDLE->DONE with out_valid high after edge T+1:
  - b zero: {sign, 8'hFF, 23'h0}.
  - otherwise a zero: {sign, 31'h0}.
- DIV: 25 iterations computing q = floor(ma * 2^24 / mb), 25 bits, using a 26-bit partial remainder.
  - Each cycle: shift remainder left by 1 and subtract mb. If the difference is non-negative, keep it and shift in q bit 1; otherwise restore and shift in 0.
  - Iteration counter is 5 bits and counts 0..24. On count 24, go to NORM.
- NORM: one cycle.
  - q[24]=1: mantissa = q[23:1], exponent = exp_t.
  - q[24]=0: mantissa = q[22:0], exponent = exp_t - 1. q[23] is guaranteed 1 in this case.
  - Register result and go to DONE.
  - Normal-path latency: out_valid high after edge T+26.
- DONE: out_valid=1. result is held stable until out_valid&&out_ready. On that handshake, go to IDLE and drop out_valid; in_ready rises the next cycle.
- No input acceptance outside IDLE, so there is no back-to-back overlap. Minimum issue interval is 27 cycles (normal path) or 2 cycles (special path) when out_ready=1.
- Exponent out of range, without the optional feature: the low 8 bits of the final exponent are packed (wrap), matching the multiplier.

Optional Feature:
- Macro FP_DIV_SATURATE_EN.
- Defined: in NORM the signed final exponent is checked.
  - >= 255: result = {sign, 8'hFF, 23'h0} (infinity).
  - <= 0: result = {sign, 31'h0} (zero).
- Undefined: exponent bits wrap as stated above. No extra logic.

Decomposition:
- Shared package fp_pkg holds:
  - constants FP_EXP_W=8, FP_MANT_W=23, FP_BIAS=127, FP_EXP_INF=8'hFF;
  - the state enum type fp_div_state_t {IDLE, DIV, NORM, DONE};
  - helper functions fp_is_zero(x) and fp_pack(sign, exp, mant).
- The multiplier is to be retrofitted onto the same package.
- One sub-module is natural: fp_div_mant_core. It holds the restoring division datapath (remainder, quotient shift register, counter) with start/done strobes.
- The FSM, special-case handling and normalisation stay in fp_divider.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> result 0x40400000. out_valid rises exactly 26 cycles after the accept edge; in_ready=0 throughout.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated, not RNE 0x3EAAAAAB). This exercises the q[24]=0 normalise path.
- 0xBF800000 / 0x00000000 (-1/0) -> 0xFF800000 after 1 cycle. 0x00000000 / 0x40A00000 (0/5) -> 0x00000000 after 1 cycle.
- 0x7F000000 / 0x3E800000 (final exponent 256):
  - with FP_DIV_SATURATE_EN -> 0x7F800000;
  - without -> 0x00000000 (wrapped).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. result stays stable and in_ready stays 0; a new in_valid is ignored. Release out_ready: one handshake, then IDLE.
- Assert rst during DIV iteration 12, then release. All outputs equal their reset values next cycle, no spurious out_valid appears, and a fresh 6/2 still returns 0x40400000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP32 helpers for the accelerator datapath (divider, and the multiplier once retrofitted).
// Holds format constants, the divider state type and small pack/zero helpers.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_BIAS   = 127;
  localparam logic [FP_EXP_W-1:0] FP_EXP_INF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } fp_div_state_t;

  // Flush-to-zero: x is the exponent field; any operand with a zero exponent counts as zero.
  function automatic logic fp_is_zero(input logic [FP_EXP_W-1:0] x);
    return x == '0;
  endfunction

  function automatic logic [FP_EXP_W+FP_MANT_W:0] fp_pack(
    input logic                 sign,
    input logic [FP_EXP_W-1:0]  exp,
    input logic [FP_MANT_W-1:0] mant
  );
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/fp_div_mant_core.sv
// Restoring mantissa divider: one quotient bit per clock, q = floor(ma * 2^(MANT_W+1) / mb).
// start loads the operands; done is high during the cycle of the final iteration.
module fp_div_mant_core #(
  parameter int MANT_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W:0]   ma,
  input  logic [MANT_W:0]   mb,
  output logic              done,
  output logic [MANT_W+1:0] q
);

  localparam int Q_W   = MANT_W + 2;
  localparam int R_W   = MANT_W + 3;
  localparam int CNT_W = $clog2(Q_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(Q_W - 1);

  logic [R_W-1:0]   rem;
  logic [R_W-1:0]   diff;
  logic [MANT_W:0]  divisor;
  logic [CNT_W-1:0] cnt;
  logic             running;
  logic             q_bit;

  // Compare before shifting, so the first iteration produces the integer bit of ma/mb.
  assign diff  = rem - {2'b00, divisor};
  assign q_bit = ~diff[R_W-1];
  assign done  = running && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rem     <= '0;
      divisor <= '0;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= {2'b00, ma};
      divisor <= mb;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      rem <= (q_bit ? diff : rem) << 1;
      q   <= {q[Q_W-2:0], q_bit};
      if (cnt == LAST) begin
        cnt     <= '0;
        running <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_divider.sv
// Iterative FP32 divider (a / b) with valid/ready handshakes, truncation rounding, flush-to-zero.
// Define FP_DIV_SATURATE_EN to saturate out-of-range exponents to inf/zero instead of wrapping.
module fp_divider
  import fp_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MANT_W = FP_MANT_W,
  parameter int BIAS   = FP_BIAS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W:0]   a,
  input  logic [EXP_W+MANT_W:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   result,
  output logic                    busy
);

  localparam int W   = 1 + EXP_W + MANT_W;
  localparam int Q_W = MANT_W + 2;

  // The wrapping build only ever packs the low exponent bits, so it keeps just those.
`ifdef FP_DIV_SATURATE_EN
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_SAT  = XW'(2 ** EXP_W - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
`else
  localparam int XW = EXP_W;
`endif

  fp_div_state_t state, next_state;

  logic [EXP_W-1:0]      a_exp, b_exp;
  logic                  a_zero, b_zero, special, accept;
  logic signed [XW-1:0]  exp_t;
  logic                  sign_q, a_zero_q, b_zero_q;
  logic signed [XW-1:0]  exp_q;
  logic                  core_start, core_done;
  logic [Q_W-1:0]        core_q;
  logic signed [XW-1:0]  exp_f;
  logic [MANT_W-1:0]     mant_f;
  logic [W-1:0]          norm_result;

  assign a_exp      = a[W-2 -: EXP_W];
  assign b_exp      = b[W-2 -: EXP_W];
  assign a_zero     = fp_is_zero(a_exp);
  assign b_zero     = fp_is_zero(b_exp);
  assign special    = a_zero || b_zero;
  assign accept     = in_valid && (state == IDLE);
  assign core_start = accept && !special;
  assign exp_t      = XW'(a_exp) - XW'(b_exp) + XW'(BIAS);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  fp_div_mant_core #(
    .MANT_W(MANT_W)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .start(core_start),
    .ma   ({1'b1, a[MANT_W-1:0]}),
    .mb   ({1'b1, b[MANT_W-1:0]}),
    .done (core_done),
    .q    (core_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Special operands skip DIV but still use the NORM slot, where the result register is loaded.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = special ? NORM : DIV;
      DIV:  if (core_done) next_state = NORM;
      NORM: next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q   <= 1'b0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      exp_q    <= '0;
      result   <= '0;
    end else begin
      if (accept) begin
        sign_q   <= a[W-1] ^ b[W-1];
        a_zero_q <= a_zero;
        b_zero_q <= b_zero;
        exp_q    <= exp_t;
      end
      if (state == NORM) begin
        result <= norm_result;
      end
    end
  end

  // A quotient below 1.0 always has its next bit set, so one left shift normalises it.
  always_comb begin
    exp_f       = core_q[Q_W-1] ? exp_q : exp_q - XW'(1);
    mant_f      = core_q[Q_W-1] ? core_q[MANT_W:1] : core_q[MANT_W-1:0];
    norm_result = '0;
    if (b_zero_q) begin
      norm_result = fp_pack(sign_q, FP_EXP_INF, '0);
    end else if (a_zero_q) begin
      norm_result = fp_pack(sign_q, '0, '0);
    end else begin
`ifdef FP_DIV_SATURATE_EN
      if (exp_f >= EXP_SAT) begin
        norm_result = fp_pack(sign_q, FP_EXP_INF, '0);
      end else if (exp_f <= EXP_ZERO) begin
        norm_result = fp_pack(sign_q, '0, '0);
      end else begin
        norm_result = fp_pack(sign_q, exp_f[EXP_W-1:0], mant_f);
      end
`else
      norm_result = fp_pack(sign_q, exp_f, mant_f);
`endif
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: directed operands with hand-computed quotients and latencies.
// A negedge monitor pops expected results on every output handshake.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int check_count = 0;
  int pass_count  = 0;
  logic [31:0] expected_q[$];

  always #5 clk = ~clk;

  fp_divider dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    check_count++;
    if (actual === required) pass_count++;
    else $display("[TB] FAIL %s: actual %h required %h", name, actual, required);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expected_q.size() == 0) check_output("spurious_out_valid", 32'(out_valid), 32'd0);
      else check_output("result", result, expected_q.pop_front());
    end
  end

  task automatic apply_stimulus(input logic [31:0] op_a, input logic [31:0] op_b,
                                input logic [31:0] exp_res, input int exp_lat);
    int n = 0;
    bit ready_high = 1'b0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("ready_before_issue", 32'(in_ready), 32'd1);
    a = op_a;
    b = op_b;
    in_valid = 1'b1;
    expected_q.push_back(exp_res);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!out_valid && in_ready) ready_high = 1'b1;
    end while (!out_valid && n < 40);
    check_output("latency", 32'(n), 32'(exp_lat));
    check_output("in_ready_low_while_busy", 32'(ready_high), 32'd0);
    check_output("busy_in_done", 32'(busy), 32'd1);
    if (out_ready) begin
      @(posedge clk); #1;
      check_output("idle_after_handshake", 32'({in_ready, out_valid, busy}), 32'b100);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_in_ready",  32'(in_ready),  32'd1);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_result",    result,         32'h0);
    check_output("reset_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    apply_stimulus(32'h40C00000, 32'h40000000, 32'h40400000, 26);
    apply_stimulus(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26);
    apply_stimulus(32'hBF800000, 32'h00000000, 32'hFF800000, 1);
    apply_stimulus(32'h00000000, 32'h40A00000, 32'h00000000, 1);
    apply_stimulus(32'h40000000, 32'h00400000, 32'h7F800000, 1);
`ifdef FP_DIV_SATURATE_EN
    apply_stimulus(32'h7F000000, 32'h3E800000, 32'h7F800000, 26);
`else
    apply_stimulus(32'h7F000000, 32'h3E800000, 32'h00000000, 26);
`endif

    // Backpressure: 10/2 held in DONE while a competing request is offered.
    out_ready = 1'b0;
    apply_stimulus(32'h41200000, 32'h40000000, 32'h40A00000, 26);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_output("held_result", result, 32'h40A00000);
      check_output("held_handshake", 32'({in_ready, out_valid}), 32'b01);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_output("release_to_idle", 32'({in_ready, out_valid, busy}), 32'b100);
    @(posedge clk); #1;
    check_output("no_extra_accept", 32'(busy), 32'd0);

    // Reset in the middle of the mantissa iterations.
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    expected_q.push_back(32'h40400000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    expected_q.delete();
    @(posedge clk); #1;
    check_output("abort_in_ready",  32'(in_ready),  32'd1);
    check_output("abort_out_valid", 32'(out_valid), 32'd0);
    check_output("abort_result",    result,         32'h0);
    check_output("abort_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1'b1;
      end
      check_output("no_valid_after_abort", 32'(seen), 32'd0);
    end
    apply_stimulus(32'h40C00000, 32'h40000000, 32'h40400000, 26);

    check_output("scoreboard_drained", 32'(expected_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
